// File: rtl/interrupt_controller.sv
// Interrupt controller for a single-cycle CPU. Detects rising edges on the IRQ
// lines and holds them as pending requests. When interrupts are enabled it
// redirects the next PC to the ISR vector and saves the return address, then
// restores that address on RETI. Only one ISR runs at a time.
module interrupt_controller #(
  parameter int unsigned N_IRQ = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_IRQ-1:0] IRQ,
  input  logic             IE_SET,
  input  logic             IE_CLR,
  input  logic             RETI,
  input  logic             STALL,
  input  logic [31:0]      PC_NEXT,
  input  logic [31:0]      VECTOR,
  output logic [31:0]      PC_OUT,
  output logic             PC_SEL,
  output logic [31:0]      EPC,
  output logic [2:0]       CAUSE,
  output logic             IN_ISR,
  output logic             IE
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               ie_q, ie_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   irq_prev_q;
  logic [31:0]        epc_q, epc_d;
  logic [2:0]         cause_q, cause_d;

  logic [N_IRQ-1:0]   edges;
  logic [2:0]         sel_idx;
  logic               take;
  logic               ret;

  // Lowest-numbered pending line wins (index 0 is the highest priority).
  always_comb begin
    logic found;
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (pending_q[i] && !found) begin
        sel_idx = 3'(i);
        found   = 1'b1;
      end
    end
  end

  // Take only acts on already-registered requests; a same-cycle edge waits a cycle.
  always_comb begin
    edges = IRQ & ~irq_prev_q;
    take  = (state_q == IDLE) && ie_q && (|pending_q) && !STALL;
    ret   = (state_q == ACTIVE) && RETI && !STALL;
  end

  // Next-state, pending/EPC/CAUSE updates and PC override.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    PC_SEL    = 1'b0;
    PC_OUT    = PC_NEXT;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          PC_SEL             = 1'b1;
          PC_OUT             = VECTOR;
          epc_d              = PC_NEXT;
          cause_d            = sel_idx;
          pending_d[sel_idx] = 1'b0;
          state_d            = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ret) begin
          PC_SEL  = 1'b1;
          PC_OUT  = epc_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edges are merged after the clear so a fresh edge on the line being taken keeps it pending.
    pending_d = pending_d | edges;
  end

  // Global enable: clear dominates set.
  always_comb begin
    ie_d = ie_q;
    if (IE_CLR) begin
      ie_d = 1'b0;
    end else if (IE_SET) begin
      ie_d = 1'b1;
    end
  end

  // State registers; irq_prev resets high so lines already asserted give no edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ie_q       <= 1'b0;
      pending_q  <= '0;
      irq_prev_q <= '1;
      epc_q      <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      pending_q  <= pending_d;
      irq_prev_q <= IRQ;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    EPC    = epc_q;
    CAUSE  = cause_q;
    IN_ISR = (state_q == ACTIVE);
    IE     = ie_q;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_interrupt_controller;

  localparam int N = 4;
  localparam logic [31:0] VEC = 32'h0000_2DE4;

  logic         clk = 1'b0;
  logic         rst, ie_set, ie_clr, reti, stall;
  logic [N-1:0] irq;
  logic [31:0]  pc_next, pc_out, epc;
  logic         pc_sel, in_isr, ie;
  logic [2:0]   cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.N_IRQ(N)) dut (
    .CLK(clk), .RST(rst), .IRQ(irq), .IE_SET(ie_set), .IE_CLR(ie_clr),
    .RETI(reti), .STALL(stall), .PC_NEXT(pc_next), .VECTOR(VEC),
    .PC_OUT(pc_out), .PC_SEL(pc_sel), .EPC(epc), .CAUSE(cause),
    .IN_ISR(in_isr), .IE(ie)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        set, clr, reti, stall;
    logic [31:0] pcn;
    logic        sel;
    logic [31:0] out;
    logic        isr;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        ie;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: one outstanding ISR, a set of pending line numbers.
  bit          m_active, m_ie;
  bit          m_pend [N];
  bit          m_prev [N];
  bit [31:0]   m_epc;
  int          m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] q, input logic s, input logic c,
                       input logic rt, input logic st, input logic [31:0] pcn);
    @(negedge clk);
    rst = r; irq = q; ie_set = s; ie_clr = c; reti = rt; stall = st; pc_next = pcn;
    #1;
  endtask

  function automatic int first_pending();
    for (int i = 0; i < N; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic bit model_take();
    return !m_active && m_ie && (first_pending() >= 0) && !stall;
  endfunction

  function automatic bit model_ret();
    return m_active && reti && !stall;
  endfunction

  task automatic model_check();
    logic [31:0] e_out;
    bit          e_sel;
    e_sel = model_take() || model_ret();
    e_out = model_take() ? VEC : (model_ret() ? m_epc : pc_next);
    chk("m_pc_sel", 32'(pc_sel), 32'(e_sel));
    chk("m_pc_out", pc_out, e_out);
    chk("m_in_isr", 32'(in_isr), 32'(m_active));
    chk("m_epc",    epc, m_epc);
    chk("m_cause",  32'(cause), 32'(m_cause));
    chk("m_ie",     32'(ie), 32'(m_ie));
  endtask

  task automatic model_update();
    int k;
    bit tk, rt;
    if (rst) begin
      m_active = 0; m_ie = 0; m_epc = 0; m_cause = 0;
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 1; end
      return;
    end
    tk = model_take();
    rt = model_ret();
    k  = first_pending();
    if (tk) begin
      m_epc = pc_next; m_cause = k; m_pend[k] = 0; m_active = 1;
    end
    if (rt) m_active = 0;
    for (int i = 0; i < N; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq[i];
    end
    if (ie_clr) m_ie = 0;
    else if (ie_set) m_ie = 1;
  endtask

  initial begin
    logic [N-1:0] rq;

    // rst irq set clr reti stall pcn | sel out isr epc cause ie
    tbl.push_back(vec_t'{0,4'b0000,1,0,0,0,32'h100, 0,32'h100, 0,32'h000,0,0});
    tbl.push_back(vec_t'{0,4'b0100,0,0,0,0,32'h100, 0,32'h100, 0,32'h000,0,1});
    tbl.push_back(vec_t'{0,4'b0100,0,0,0,0,32'h100, 1,VEC,     0,32'h000,0,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h200, 0,32'h200, 1,32'h100,2,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,1,0,32'h204, 1,32'h100, 1,32'h100,2,1});
    tbl.push_back(vec_t'{0,4'b1010,0,0,0,0,32'h104, 0,32'h104, 0,32'h100,2,1});
    tbl.push_back(vec_t'{0,4'b1010,0,0,0,0,32'h108, 1,VEC,     0,32'h100,2,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h300, 0,32'h300, 1,32'h108,1,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,1,0,32'h304, 1,32'h108, 1,32'h108,1,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h10C, 1,VEC,     0,32'h108,1,1});
    tbl.push_back(vec_t'{0,4'b0000,0,1,0,0,32'h400, 0,32'h400, 1,32'h10C,3,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,1,0,32'h404, 1,32'h10C, 1,32'h10C,3,0});
    tbl.push_back(vec_t'{0,4'b0001,0,0,0,0,32'h110, 0,32'h110, 0,32'h10C,3,0});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h114, 0,32'h114, 0,32'h10C,3,0});
    tbl.push_back(vec_t'{0,4'b0000,1,1,0,0,32'h118, 0,32'h118, 0,32'h10C,3,0});
    tbl.push_back(vec_t'{0,4'b0000,1,0,0,0,32'h11C, 0,32'h11C, 0,32'h10C,3,0});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h120, 1,VEC,     0,32'h10C,3,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,1,1,32'h500, 0,32'h500, 1,32'h120,0,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,1,0,32'h504, 1,32'h120, 1,32'h120,0,1});
    tbl.push_back(vec_t'{0,4'b0100,0,0,0,0,32'h124, 0,32'h124, 0,32'h120,0,1});
    tbl.push_back(vec_t'{0,4'b0100,0,0,0,1,32'h128, 0,32'h128, 0,32'h120,0,1});
    tbl.push_back(vec_t'{0,4'b0000,0,0,0,0,32'h128, 1,VEC,     0,32'h120,0,1});
    tbl.push_back(vec_t'{1,4'b0001,0,0,0,0,32'h600, 0,32'h600, 1,32'h128,2,1});
    tbl.push_back(vec_t'{0,4'b0001,0,0,0,0,32'h010, 0,32'h010, 0,32'h000,0,0});
    tbl.push_back(vec_t'{0,4'b0001,1,0,0,0,32'h014, 0,32'h014, 0,32'h000,0,0});
    tbl.push_back(vec_t'{0,4'b0001,0,0,0,0,32'h018, 0,32'h018, 0,32'h000,0,1});
    tbl.push_back(vec_t'{0,4'b0010,0,1,0,0,32'h01C, 0,32'h01C, 0,32'h000,0,1});
    tbl.push_back(vec_t'{0,4'b0000,1,0,0,0,32'h020, 0,32'h020, 0,32'h000,0,0});
    tbl.push_back(vec_t'{0,4'b0010,0,0,0,0,32'h024, 1,VEC,     0,32'h000,0,1});
    tbl.push_back(vec_t'{0,4'b0010,0,0,1,0,32'h700, 1,32'h024, 1,32'h024,1,1});
    tbl.push_back(vec_t'{0,4'b0010,0,0,0,0,32'h028, 1,VEC,     0,32'h024,1,1});
    tbl.push_back(vec_t'{0,4'b0010,0,0,0,0,32'h800, 0,32'h800, 1,32'h028,1,1});
    tbl.push_back(vec_t'{0,4'b0010,0,0,1,0,32'h804, 1,32'h028, 1,32'h028,1,1});
    tbl.push_back(vec_t'{0,4'b0010,0,0,1,0,32'h02C, 0,32'h02C, 0,32'h028,1,1});

    // Reset, then check the idle outputs straight out of reset.
    drive(1, '0, 0, 0, 0, 0, 32'h0); model_update();
    drive(1, '0, 0, 0, 0, 0, 32'h0); model_update();
    drive(0, '0, 0, 0, 0, 0, 32'h44);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_pc_out", pc_out, 32'h44);
    chk("rst_in_isr", 32'(in_isr), 32'd0);
    chk("rst_epc",    epc, 32'h0);
    chk("rst_cause",  32'(cause), 32'd0);
    chk("rst_ie",     32'(ie), 32'd0);
    model_update();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].irq, tbl[i].set, tbl[i].clr, tbl[i].reti, tbl[i].stall, tbl[i].pcn);
      chk($sformatf("v%0d_pc_sel", i), 32'(pc_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d_pc_out", i), pc_out, tbl[i].out);
      chk($sformatf("v%0d_in_isr", i), 32'(in_isr), 32'(tbl[i].isr));
      chk($sformatf("v%0d_epc", i),    epc, tbl[i].epc);
      chk($sformatf("v%0d_cause", i),  32'(cause), 32'(tbl[i].cause));
      chk($sformatf("v%0d_ie", i),     32'(ie), 32'(tbl[i].ie));
      model_update();
    end

    // Randomized traffic against the model.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) rq = rq ^ N'($urandom);
      drive(($urandom_range(0, 299) == 0), rq,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom & 32'hFFFF_FFFC);
      model_check();
      model_update();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
